// File: rtl/instr_queue.sv
// instr_queue: fetch-to-decode decoupling FIFO that drops its contents on a redirect.
// Define INSTR_QUEUE_BYPASS_EN to pass fetch straight to decode when the queue is empty.
module instr_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     flush_i,
  input  logic                     valid_i,
  input  logic [31:0]              instr_i,
  input  logic [31:0]              pc_i,
  output logic                     stall_o,
  output logic                     valid_o,
  output logic [31:0]              instr_o,
  output logic [31:0]              pc_o,
  input  logic                     ready_i,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          empty, push, pop, byp;
  assign empty   = count == '0;
  assign stall_o = count == (AW+1)'(DEPTH);
  assign count_o = count;
  assign pop     = ~empty & ready_i & ~flush_i;
`ifdef INSTR_QUEUE_BYPASS_EN
  assign byp = empty & ~flush_i & rstn_i;
`else
  assign byp = 1'b0;
`endif
  // a bypassed instruction taken by decode in the same cycle is never stored
  assign push    = valid_i & ~stall_o & ~flush_i & ~(byp & ready_i);
  assign valid_o = byp ? valid_i : ~empty;
  assign {instr_o, pc_o} = byp ? {instr_i, pc_i} : mem[rd_ptr];
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {instr_i, pc_i};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
endmodule

// File: doc/instr_queue.md
Name: instr_queue

Overview:
- Decoupling FIFO between the fetch stage and the decode stage.
- Captures {instr, pc} pairs from fetch and presents them in order to decode with a valid/ready handshake.
- Drives the fetch stall input from its own fullness.
- Discards all buffered instructions on a redirect (flush_i), so decode never sees wrong-path instructions.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2.

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  reset, asynchronous, active-low.
- flush_i  in  1  redirect/jump taken; drop all entries. Tied to the same signal as fetch new_pc_i.
- valid_i  in  1  fetch presents a valid instruction.
- instr_i  in  32  instruction word from fetch.
- pc_i  in  32  pc of instr_i.
- stall_o  out  1  queue cannot accept; drives fetch stall_i.
- valid_o  out  1  head entry valid for decode.
- instr_o  out  32  head instruction.
- pc_o  out  32  head pc.
- ready_i  in  1  decode consumes the head this cycle.
- count_o  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Storage: DEPTH x 64-bit entry array, wr_ptr and rd_ptr of $clog2(DEPTH) bits, count of $clog2(DEPTH)+1 bits.
- Pointers wrap naturally modulo DEPTH.
- Reset (async, any time including mid-operation):
  - wr_ptr=rd_ptr=count=0.
  - All entries = 0.
  - valid_o=0, stall_o=0, instr_o=0, pc_o=0, count_o=0.
- push = valid_i & ~stall_o & ~flush_i.
- pop = valid_o & ready_i & ~flush_i.
- stall_o = (count == DEPTH), driven combinationally from registered state only. No combinational path from ready_i to stall_o.
- valid_o = (count != 0).
- instr_o/pc_o = entry[rd_ptr]. When empty they show stale storage content; don't-care.
- Push: entry[wr_ptr] <= {instr_i, pc_i}; wr_ptr+1.
- Pop: rd_ptr+1.
- Count update: count += push - pop.
- Latency: 1 cycle from push to valid_o (no bypass in base build).
- Simultaneous push and pop:
  - Not full: both happen, count unchanged.
  - Full: push is blocked by stall_o, pop proceeds, count = DEPTH-1 next cycle. No same-cycle refill when full.
- Empty with ready_i=1: no pop, no underflow, count stays 0.
- Flush has priority over push and pop in the same cycle:
  - Next cycle: rd_ptr=wr_ptr=0, count=0, valid_o=0, stall_o=0.
  - Storage contents are not cleared.
  - The instruction presented on valid_i in the flush cycle is dropped.
- Order is strictly FIFO. No entry is duplicated or skipped across pointer wrap.
- count_o = count.

Optional Feature:
- Macro: INSTR_QUEUE_BYPASS_EN.
- Defined: when count==0 and flush_i=0, outputs bypass storage:
  - valid_o=valid_i, instr_o=instr_i, pc_o=pc_i, same cycle (0-cycle latency).
  - If ready_i=1 that cycle, the instruction is consumed and not written (count stays 0).
  - If ready_i=0, it is written normally (count becomes 1).
  - Non-empty behaviour is unchanged.
- Undefined: no bypass; valid_o depends only on registered count; 1-cycle latency as above.

Test Plan:
- DEPTH=4, ready_i=0, push pc 0x0,0x4,0x8,0xC with instr 0xA0..0xA3 -> stall_o=1 and count_o=4 after 4th push. 5th valid_i (pc 0x10) not accepted. Then ready_i=1 -> pops pc 0x0,0x4,0x8,0xC in order, valid_o=0 afterwards, stall_o drops the cycle after the first pop.
- count=2, valid_i=1 and ready_i=1 for 6 cycles, pc incrementing by 4 -> count_o stays 2. Outputs appear in push order across pointer wrap (12 total transfers, none lost).
- count=3 then flush_i=1 with valid_i=1 (pc 0x40) -> next cycle valid_o=0, count_o=0, stall_o=0. Next push pc 0x80 appears at head with no 0x40.
- Empty queue, ready_i=1, valid_i=0 for 5 cycles -> count_o stays 0, valid_o=0, rd_ptr does not move. Next push then pop returns the pushed value.
- Reset asserted with count=3, asynchronously mid-cycle -> valid_o=0, count_o=0, instr_o=pc_o=0 immediately. After release, first push pc 0x100 pops correctly.
- With INSTR_QUEUE_BYPASS_EN, empty queue, valid_i=1 pc 0x20, ready_i=1 -> valid_o=1, pc_o=0x20 same cycle, count_o stays 0. With ready_i=0 -> count_o=1 next cycle. Without the macro -> valid_o rises one cycle after push.
